// File: rtl/port_uart_pkg.sv
// Shared definitions for the CPU-port UART transmitter: FSM encoding and
// bit positions of the request and status words.
package port_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int ACK       = 0;
  localparam int FULL      = 1;
  localparam int BUSY      = 2;
  localparam int COUNT_LSB = 8;
  localparam int REQ       = 8;

endpackage

// File: rtl/port_uart_tx_byte_fifo.sv
// Circular-buffer FIFO with a combinational read port so the head entry is
// available in the same cycle it is popped.
module byte_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/port_uart_tx.sv
// CPU output-port console: toggle-handshake byte writes are queued and sent
// as 8N1 frames; handshake and status are returned on the CPU input port.
module port_uart_tx
  import port_uart_pkg::*;
#(
  parameter int CLK_DIV         = 16,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int WIDTH_D         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH_D-1:0] cpu_port_out,
  output logic [WIDTH_D-1:0] cpu_port_in,
  output logic               uart_txd
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  logic                     req_seen_q, req_seen_d;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]               fifo_pop_data;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  tx_state_e                state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               shift_q, shift_d;
  logic                     txd_q, txd_d;
  logic [WIDTH_D-1:0]       status_q, status_d;
  logic                     unused_port_bits;

  assign unused_port_bits = ^{cpu_port_out[WIDTH_D-1:REQ+1]};

  // A pending request simply waits here while the FIFO is full.
  assign fifo_push  = (cpu_port_out[REQ] != req_seen_q) && !fifo_full;
  assign req_seen_d = fifo_push ? cpu_port_out[REQ] : req_seen_q;

  byte_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (cpu_port_out[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_pop_data;
          txd_d    = 1'b0;
          cnt_d    = RELOAD;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          txd_d     = shift_q[0];
          bit_idx_d = '0;
          cnt_d     = RELOAD;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_pop_data;
            txd_d    = 1'b0;
            cnt_d    = RELOAD;
            state_d  = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_d       = '0;
    status_d[ACK]  = req_seen_q;
    status_d[FULL] = fifo_full;
    status_d[BUSY] = !fifo_empty || (state_q != IDLE);
    status_d[COUNT_LSB +: FIFO_DEPTH_LOG2 + 1] = fifo_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_seen_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      status_q   <= '0;
    end else begin
      req_seen_q <= req_seen_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      status_q   <= status_d;
    end
  end

  assign cpu_port_in = status_q;
  assign uart_txd    = txd_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: a frame-position model of the console predicts the
// serial line and status word every cycle, plus directed literal checks.
module tb_port_uart_tx;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_port_out = 32'h0;
  logic [31:0] cpu_port_in;
  logic        uart_txd;

  int checks = 0;
  int failures = 0;
  logic tog = 1'b0;

  port_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH_LOG2(4), .WIDTH_D(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_port_out (cpu_port_out),
    .cpu_port_in  (cpu_port_in),
    .uart_txd     (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of bytes plus position within the current frame (-1 = idle).
  logic [7:0]  m_q[$];
  int          m_pos = -1;
  logic [7:0]  m_cur = 8'h00;
  logic        m_req = 1'b0;
  logic        m_txd = 1'b1;
  logic [31:0] m_status = 32'h0;

  task automatic model_step();
    int sz;
    int b;
    logic do_push;
    if (reset) begin
      m_q.delete();
      m_pos = -1;
      m_req = 1'b0;
      m_txd = 1'b1;
      m_status = 32'h0;
      return;
    end
    sz = m_q.size();
    m_status = {16'h0, 8'(sz), 5'b0, (sz != 0 || m_pos != -1), (sz == 16), m_req};
    do_push = (cpu_port_out[8] != m_req) && (sz < 16);
    if (m_pos == -1) begin
      if (sz != 0) begin m_cur = m_q.pop_front(); m_pos = 0; end
    end else if (m_pos == 10*D - 1) begin
      if (sz != 0) begin m_cur = m_q.pop_front(); m_pos = 0; end
      else m_pos = -1;
    end else begin
      m_pos++;
    end
    if (do_push) begin
      m_q.push_back(cpu_port_out[7:0]);
      m_req = cpu_port_out[8];
    end
    if (m_pos == -1) m_txd = 1'b1;
    else begin
      b = m_pos / D;
      if (b == 0) m_txd = 1'b0;
      else if (b == 9) m_txd = 1'b1;
      else m_txd = m_cur[b-1];
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("model_txd", {31'b0, uart_txd}, {31'b0, m_txd});
    chk("model_status", cpu_port_in, m_status);
  end

  task automatic send(input logic [7:0] b);
    tog = ~tog;
    cpu_port_out = {23'b0, tog, b};
  endtask

  task automatic wait_ack(input string name, input int limit);
    int n = 0;
    while (cpu_port_in[0] !== tog && n < limit) begin @(negedge clk); n++; end
    chk(name, {31'b0, cpu_port_in[0]}, {31'b0, tog});
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (cpu_port_in[2] !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    chk(name, {31'b0, cpu_port_in[2]}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_bits;
    logic [7:0] hold_tog;
    int lowcnt;

    // Reset and quiet line
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_txd", {31'b0, uart_txd}, 32'h1);
    chk("reset_status", cpu_port_in, 32'h0);
    reset = 1'b0;
    lowcnt = 0;
    repeat (100) begin @(negedge clk); if (uart_txd !== 1'b1) lowcnt++; end
    chk("quiet_line", lowcnt, 0);
    chk("quiet_status", cpu_port_in, 32'h0);

    // Single byte 0x55
    tog = 1'b1;
    cpu_port_out = 32'h0000_0155;
    @(negedge clk);
    chk("ack_after_1_edge", {31'b0, cpu_port_in[0]}, 32'h0);
    @(negedge clk);
    chk("ack_after_2_edges", {31'b0, cpu_port_in[0]}, 32'h1);
    exp_bits = 10'b10_1010_1010;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("frame55_bit%0d", i), {31'b0, uart_txd}, {31'b0, exp_bits[i]});
      repeat (D) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("busy_clear_55", {31'b0, cpu_port_in[2]}, 32'h0);

    // Three bytes back to back
    send(8'h41); @(negedge clk);
    send(8'h42); @(negedge clk);
    send(8'h43);
    chk("b2b_start0", {31'b0, uart_txd}, 32'h0);
    repeat (2) @(negedge clk);
    chk("b2b_count2", {24'b0, cpu_port_in[15:8]}, 32'h2);
    repeat (37) @(negedge clk);
    chk("b2b_stop0", {31'b0, uart_txd}, 32'h1);
    @(negedge clk);
    chk("b2b_start1_nogap", {31'b0, uart_txd}, 32'h0);
    repeat (40) @(negedge clk);
    chk("b2b_start2_nogap", {31'b0, uart_txd}, 32'h0);
    repeat (39) @(negedge clk);
    chk("b2b_stop2", {31'b0, uart_txd}, 32'h1);
    repeat (4) @(negedge clk);
    wait_idle("b2b_idle", 50);

    // Fill the FIFO while the first frame is in flight
    for (int i = 0; i < 17; i++) begin
      send(8'h60 + 8'(i));
      @(negedge clk);
    end
    send(8'h99);
    hold_tog = {7'b0, tog};
    @(negedge clk);
    chk("full_count16", {24'b0, cpu_port_in[15:8]}, 32'h10);
    chk("full_flag", {31'b0, cpu_port_in[1]}, 32'h1);
    repeat (10) @(negedge clk);
    chk("no_ack_when_full", {31'b0, cpu_port_in[0]}, {31'b0, ~hold_tog[0]});
    wait_ack("ack_after_pop", 60);
    chk("count_back_16", {24'b0, cpu_port_in[15:8]}, 32'h10);
    repeat (4) @(negedge clk);
    wait_idle("fill_drained", 1000);

    // Toggle without changing data
    tog = 1'b1;
    cpu_port_out = 32'h0000_0100;
    wait_ack("zero_ack1", 10);
    tog = 1'b0;
    cpu_port_out = 32'h0000_0000;
    wait_ack("zero_ack0", 10);
    repeat (4) @(negedge clk);
    wait_idle("zero_idle", 200);

    // Reset in the middle of a data bit with two bytes queued
    send(8'hA5); @(negedge clk);
    send(8'h11); @(negedge clk);
    send(8'h22);
    repeat (12) @(negedge clk);
    chk("pre_reset_count2", {24'b0, cpu_port_in[15:8]}, 32'h2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    cpu_port_out = 32'h0;
    tog = 1'b0;
    #1;
    chk("reset_txd_immediate", {31'b0, uart_txd}, 32'h1);
    chk("reset_status_immediate", cpu_port_in, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    lowcnt = 0;
    repeat (100) begin @(negedge clk); if (uart_txd !== 1'b1) lowcnt++; end
    chk("no_frame_after_reset", lowcnt, 0);
    chk("status_after_reset", cpu_port_in, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
